// File: rtl/div_pkg.sv
// div_pkg: shared types and sizes for the multi-cycle divider.
`ifndef ALUOP_DIV
`define ALUOP_DIV 8'h1A
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU 8'h1B
`endif
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  typedef enum logic [1:0] {IDLE, DIV, SIGN, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on the partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] shifted, diff;
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, dvs_i};
  assign q_o     = !diff[W+1];
  assign rem_o   = q_o ? diff[W:0] : shifted[W:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned divider for DIV/DIVU (lo=quotient, hi=remainder).
// Optional DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [7:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  div_state_t state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH:0] rem_q, rem_n;
  logic [WIDTH-1:0] quo_q, dvs_q, lo_q, hi_q, abs_a, abs_b;
  logic qneg_q, rneg_q, q_bit, sgn, op_ok, accept, zero_fast;
  assign sgn    = aluop == `ALUOP_DIV;
  assign op_ok  = sgn || aluop == `ALUOP_DIVU;
  assign accept = start && op_ok && !flush && (state_q == IDLE || state_q == DONE);
  assign abs_a  = sgn && a[WIDTH-1] ? -a : a;
  assign abs_b  = sgn && b[WIDTH-1] ? -b : b;
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = b == '0;
`else
  assign zero_fast = 1'b0;
`endif
  assign lo = lo_q;
  assign hi = hi_q;
  div_step #(.W(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .q_o  (q_bit)
  );
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = flush ? IDLE
            : accept ? (zero_fast ? DONE : DIV)
            : state_q == DIV ? (cnt_q == DIV_CNT_W'(ITER - 1) ? SIGN : DIV)
            : state_q == SIGN ? DONE
            : IDLE;
  end
  always_comb begin
    busy  = state_q == DIV || state_q == SIGN || accept;
    valid = state_q == DONE;
  end
  // The dividend shifts out of quo_q's top while quotient bits shift in below.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= abs_a;
      dvs_q  <= abs_b;
      qneg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= sgn && a[WIDTH-1];
      if (zero_fast) begin
        lo_q <= sgn && a[WIDTH-1] ? WIDTH'(1) : '1;
        hi_q <= a;
      end
    end else if (state_q == DIV && !flush) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_n;
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
    end else if (state_q == SIGN && !flush) begin
      lo_q <= qneg_q ? -quo_q : quo_q;
      hi_q <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit.
`ifndef ALUOP_DIV
`define ALUOP_DIV 8'h1A
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU 8'h1B
`endif
module tb_div_unit;
  logic clk = 0, rst = 1, flush = 0, start = 0;
  logic [7:0] aluop = 8'h00;
  logic [31:0] a = 0, b = 0;
  logic busy, valid;
  logic [31:0] lo, hi;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [31:0] lo, hi; int cyc;} exp_t;
  exp_t sb[$];
  localparam logic [7:0] OP_DIV = `ALUOP_DIV;
  localparam logic [7:0] OP_DIVU = `ALUOP_DIVU;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1;
`else
  localparam bit FAST = 0;
`endif

  div_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .aluop(aluop),
    .a(a), .b(b), .busy(busy), .valid(valid), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: lo %h hi %h at cycle %0d with nothing pending", lo, hi, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge; drives start for exactly one cycle.
  task automatic issue(input logic [7:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input bit push, input logic [31:0] el, input logic [31:0] eh);
    exp_t e;
    aluop = op;
    a = aa;
    b = bb;
    start = 1;
    if (push) begin
      e.lo = el;
      e.hi = eh;
      e.cyc = cyc + ((FAST && bb == 0) ? 1 : 34);
      sb.push_back(e);
    end
    @(negedge clk);
    check("busy_on_start", 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_lo", lo, 0);
    check("rst_hi", hi, 0);
    @(posedge clk);
    #1 rst = 0;
    // DIVU 100/7 with busy watched every cycle
    issue(OP_DIVU, 100, 7, 1, 14, 2);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      check("busy_iter", 32'(busy), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("busy_done", 32'(busy), 0);
    @(posedge clk);
    #1;
    drain();
    issue(OP_DIV, 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    drain();
    issue(OP_DIV, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 1);
    drain();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0);
    drain();
    issue(OP_DIVU, 5, 0, 1, 32'hFFFFFFFF, 5);
    drain();
    issue(OP_DIV, 32'hFFFFFFFB, 0, 1, 1, 32'hFFFFFFFB);
    drain();
    // flush at N+10 cancels the divide; lo/hi keep the -5/0 result
    issue(OP_DIVU, 12, 4, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 0);
    check("flush_lo", lo, 1);
    check("flush_hi", hi, 32'hFFFFFFFB);
    repeat (40) @(posedge clk);
    #1;
    // flush wins over a simultaneous start
    aluop = OP_DIV;
    a = 9;
    b = 3;
    start = 1;
    flush = 1;
    @(negedge clk);
    check("flush_start_busy", 32'(busy), 0);
    @(posedge clk);
    #1 start = 0;
    flush = 0;
    @(negedge clk);
    check("flush_start_after", 32'(busy), 0);
    repeat (40) @(posedge clk);
    #1;
    // start while iterating is ignored
    issue(OP_DIVU, 100, 7, 1, 14, 2);
    repeat (4) @(posedge clk);
    #1;
    issue(OP_DIVU, 50, 5, 0, 0, 0);
    drain();
    // back-to-back start in the valid cycle
    issue(OP_DIVU, 12, 4, 1, 3, 0);
    repeat (33) @(posedge clk);
    #1;
    issue(OP_DIV, 1000, 32'hFFFFFFFD, 1, 32'hFFFFFEB3, 1);
    drain();
    // reset mid-divide
    issue(OP_DIVU, 12, 4, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_lo", lo, 0);
    check("midrst_hi", hi, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
